// File: rtl/mul_if.sv
// mul_if: multiply request/response bundle between the MUL reservation station and shift_add_mul_unit
interface mul_if #(parameter int WIDTH = 32, parameter int TAG_W = 3);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_mul_type;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [TAG_W-1:0] req_tag;
   logic             resp_valid;
   logic             resp_ack;
   logic [WIDTH-1:0] resp_value;
   logic [TAG_W-1:0] resp_tag;
   modport master(output req_valid, req_mul_type, req_a, req_b, req_tag, resp_ack,
                  input req_ready, resp_valid, resp_value, resp_tag);
   modport slave(input req_valid, req_mul_type, req_a, req_b, req_tag, resp_ack,
                 output req_ready, resp_valid, resp_value, resp_tag);
endinterface

// File: rtl/shift_add_mul_unit.sv
// shift_add_mul_unit: RV32M shift-add multiplier, one multiplier bit per cycle, tagged CDB result.
// Define MUL_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are zero.
module shift_add_mul_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 3
) (
   input logic  clk,
   input logic  rst_n,
   input logic  flush,
   mul_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
   logic [1:0]         state, mul_type;
   logic [2*WIDTH-1:0] acc, mcand, fix_acc;
   logic [WIDTH-1:0]   mplier, resp_value;
   logic [CW-1:0]      cnt;
   logic [TAG_W-1:0]   tag, resp_tag;
   logic               neg, resp_valid, sign_a, sign_b, last;
   // a is signed for MULH/MULHSU, b only for MULH
   assign sign_a = bus.req_a[WIDTH-1] & (bus.req_mul_type == 2'b01 | bus.req_mul_type == 2'b10);
   assign sign_b = bus.req_b[WIDTH-1] & (bus.req_mul_type == 2'b01);
   assign fix_acc = neg ? -acc : acc;
`ifdef MUL_EARLY_TERM_EN
   assign last = mplier[WIDTH-1:1] == '0;
`else
   assign last = cnt == CW'(WIDTH - 1);
`endif
   assign bus.req_ready = rst_n && state == IDLE && !flush;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_value = resp_value;
   assign bus.resp_tag = resp_tag;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         mul_type <= '0;
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
         tag <= '0;
         neg <= 1'b0;
         resp_valid <= 1'b0;
         resp_value <= '0;
         resp_tag <= '0;
      end else if (flush) begin
         state <= IDLE;
         resp_valid <= 1'b0;
      end else
         case (state)
            IDLE:
               if (bus.req_valid) begin
                  state <= CALC;
                  mul_type <= bus.req_mul_type;
                  tag <= bus.req_tag;
                  neg <= sign_a ^ sign_b;
                  acc <= '0;
                  cnt <= '0;
                  mcand <= {{WIDTH{1'b0}}, sign_a ? -bus.req_a : bus.req_a};
                  mplier <= sign_b ? -bus.req_b : bus.req_b;
               end
            CALC: begin
               acc <= acc + (mplier[0] ? mcand : '0);
               mcand <= mcand << 1;
               mplier <= mplier >> 1;
               cnt <= cnt + CW'(1);
               state <= last ? FIX : CALC;
            end
            FIX: begin
               resp_value <= mul_type == 2'b00 ? fix_acc[WIDTH-1:0] : fix_acc[2*WIDTH-1:WIDTH];
               resp_tag <= tag;
               resp_valid <= 1'b1;
               state <= DONE;
            end
            default:
               if (bus.resp_ack) begin
                  resp_valid <= 1'b0;
                  state <= IDLE;
               end
         endcase
endmodule
